// File: rtl/dmem_lsu_if.sv
// Memory-side bus of the data load/store unit: one request held until acked,
// with read data returned in the ack cycle.
interface dmem_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wstrb,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wstrb,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: IDLE/REQ/RESP sequencer that aligns stores onto byte lanes and
// extracts/extends loads. Define XGRISCV_LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module dmem_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        memwrite,
    input  logic [1:0]  lwhb,
    input  logic [1:0]  swhb,
    input  logic        lunsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
`ifdef XGRISCV_LSU_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    dmem_lsu_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        W_NONE = 2'b00,
        W_BYTE = 2'b01,
        W_HALF = 2'b10,
        W_WORD = 2'b11
    } width_e;

    state_e      state_q, state_d;
    width_e      width_q, width_d;
    logic        lunsigned_q, lunsigned_d;
    logic [1:0]  lane_q, lane_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef XGRISCV_LSU_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
    logic        misaligned;
`endif

    width_e      sel_width;
    logic        start;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    assign sel_width = width_e'(memwrite ? swhb : lwhb);
    assign start     = req_valid && (sel_width != W_NONE);

`ifdef XGRISCV_LSU_MISALIGN_TRAP_EN
    assign misaligned = ((sel_width == W_HALF) && addr[0]) ||
                        ((sel_width == W_WORD) && (addr[1:0] != 2'b00));
`endif

    // Stall the pipeline from the cycle a request appears until the bus accepts it.
    assign busy = (state_q == S_REQ) || ((state_q == S_IDLE) && start && !reset);

    // Store lane placement, computed from the live inputs at accept time.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        st_strb = 4'b1111;
        st_data = wdata;
        case (sel_width)
            W_BYTE: begin
                st_strb = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            W_HALF: begin
                st_strb = 4'b0011 << {addr[1], 1'b0};
                st_data = {2{wdata[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = wdata;
            end
        endcase
    end

    // Load extraction from the word returned in the ack cycle.
    always_comb begin
        ld_byte  = bus.bus_rdata[{lane_q, 3'b000} +: 8];
        ld_half  = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        ld_value = bus.bus_rdata;
        case (width_q)
            W_BYTE:  ld_value = {{24{~lunsigned_q & ld_byte[7]}}, ld_byte};
            W_HALF:  ld_value = {{16{~lunsigned_q & ld_half[15]}}, ld_half};
            W_WORD:  ld_value = bus.bus_rdata;
            default: ld_value = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        lunsigned_d = lunsigned_q;
        lane_d      = lane_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_wdata_d = bus_wdata_q;
        done_d      = 1'b0;
        rdata_d     = 32'h0;
`ifdef XGRISCV_LSU_MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    width_d     = sel_width;
                    lunsigned_d = lunsigned;
                    lane_d      = addr[1:0];
`ifdef XGRISCV_LSU_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d    = S_RESP;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
`else
                    begin
`endif
                        state_d     = S_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = memwrite;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_wstrb_d = memwrite ? st_strb : 4'b0000;
                        bus_wdata_d = memwrite ? st_data : 32'h0;
                    end
                end
            end

            S_REQ: begin
                if (bus.bus_ack) begin
                    state_d     = S_RESP;
                    done_d      = 1'b1;
                    rdata_d     = bus_we_q ? 32'h0 : ld_value;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = 32'h0;
                    bus_wstrb_d = 4'b0000;
                    bus_wdata_d = 32'h0;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset wins over any request or ack arriving in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= S_IDLE;
            width_q     <= W_NONE;
            lunsigned_q <= 1'b0;
            lane_q      <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wstrb_q <= 4'b0000;
            bus_wdata_q <= 32'h0;
            done_q      <= 1'b0;
            rdata_q     <= 32'h0;
`ifdef XGRISCV_LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            lunsigned_q <= lunsigned_d;
            lane_q      <= lane_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_wdata_q <= bus_wdata_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
`ifdef XGRISCV_LSU_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign done          = done_q;
    assign rdata         = rdata_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wstrb = bus_wstrb_q;
    assign bus.bus_wdata = bus_wdata_q;
`ifdef XGRISCV_LSU_MISALIGN_TRAP_EN
    assign misalign      = misalign_q;
`endif

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  the MEM-stage instruction is a load or store.
REQ-005 memwrite  in  1  1 = store, 0 = load.
REQ-006 lwhb  in  2  load width: 11 word, 10 half, 01 byte, 00 none.
REQ-007 swhb  in  2  store width: same encoding as lwhb.
REQ-008 lunsigned  in  1  zero-extend the load (lbu/lhu); 0 = sign-extend.
REQ-009 addr  in  32  byte address from the ALU.
REQ-010 wdata  in  32  store data (rs2).
REQ-011 busy  out  1  pipeline stall request.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 rdata  out  32  aligned, extended load result, valid while done=1.
REQ-014 misalign  out  1  misaligned-access fault, valid while done=1; present only with the REQ-035 macro.
REQ-015 bus_req  out  1  memory request, held until acknowledged.
REQ-016 bus_we  out  1  write enable.
REQ-017 bus_addr  out  32  word address, {addr[31:2],2'b00}.
REQ-018 bus_wstrb  out  4  byte-lane write strobes.
REQ-019 bus_wdata  out  32  lane-replicated store data.
REQ-020 bus_ack  in  1  memory accepted the request; bus_rdata is valid in the same cycle.
REQ-021 bus_rdata  in  32  memory read word.

Function
REQ-022 The FSM SHALL use three states: IDLE, REQ, RESP.
REQ-023 IDLE->REQ when req_valid=1 and the selected width code (swhb if memwrite=1, else lwhb) is non-zero; at that point memwrite, width, lunsigned, addr and wdata are registered. Later input changes are ignored until the FSM returns to IDLE.
REQ-024 IDLE with req_valid=1 and width 00: no transition, busy=0, done=0.
REQ-025 REQ: bus_req=1 with stable bus_we, bus_addr, bus_wstrb and bus_wdata until bus_ack=1; REQ->RESP on bus_ack. An ack in the first REQ cycle is legal.
REQ-026 RESP: done=1 for exactly one cycle, then ->IDLE. A new request is accepted only in IDLE, so back-to-back accesses are separated by at least one IDLE cycle.
REQ-027 Best-case latency: accept at cycle N, bus_req at N+1, ack at N+1, done at N+2.
REQ-028 busy=1 in IDLE when a non-zero request is present (combinational), and busy=1 in REQ; busy=0 in RESP.
REQ-029 bus_ack SHALL be ignored outside REQ.
REQ-030 Store strobes: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111. Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-031 Load extraction from bus_rdata, captured on the ack cycle: byte lane addr[1:0]; half lane addr[1]; 8- or 16-bit result sign- or zero-extended to 32 bits per lunsigned. rdata=0 whenever done=0. For loads, bus_we=0 and bus_wstrb=0.

Reset
REQ-032 reset SHALL force state IDLE and busy=0, done=0, rdata=0, bus_req=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0 and misalign=0, effective from the cycle after reset is sampled.
REQ-033 Reset during REQ or RESP SHALL abandon the transaction: bus_req drops the next cycle and no done pulse is produced.
REQ-034 reset SHALL take priority over req_valid and bus_ack in the same cycle.

Configuration
REQ-035 Macro XGRISCV_LSU_MISALIGN_TRAP_EN SHALL control misaligned-access handling.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE->RESP without asserting bus_req. In RESP: done=1, misalign=1, rdata=0, and no write occurs.
- Undefined: the misalign port is absent. Low address bits are ignored per REQ-030/031 (half uses addr[1]; word ignores addr[1:0]).

Verification
REQ-036 lb: addr=0x103, lunsigned=0; bus_rdata=0x80FF_FF00 acked on the first REQ cycle -> done two cycles after accept, rdata=0xFFFF_FF80, bus_addr=0x100.
REQ-037 sh: addr=0x22, wdata=0x1234_ABCD; ack delayed 3 cycles -> bus_wstrb=1100, bus_wdata=0xABCD_ABCD, all bus outputs stable through the ack cycle, busy high until RESP.
REQ-038 lhu: addr=0x2, bus_rdata=0x9876_0000 -> rdata=0x0000_9876; the same access with lunsigned=0 -> rdata=0xFFFF_9876.
REQ-039 Reset asserted in the second REQ cycle of an lw -> bus_req=0 the next cycle, no done pulse; a following sw at addr 0x40 completes normally with bus_wstrb=1111.
REQ-040 With the macro defined, lw at addr=0x6 -> no bus_req, done=1 and misalign=1 one cycle after accept. Without the macro, the same access -> bus_addr=0x4, normal completion.
